sklansky_sub_pipe: RTL and testbench

SKLANSKY_SUB_PIPE -- requirements
Module: sklansky_sub_pipe

---
 rtl/sklansky_pkg.sv | 24 ++
 rtl/prefix_cell.sv | 17 +
 rtl/sklansky_sub_pipe.sv | 126 ++++++++++++
 tb/tb_sklansky_sub_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sklansky_pkg.sv
// Shared constants for the pipelined Sklansky subtractor: default width,
// prefix level count and the level at which the network is cut by registers.
package sklansky_pkg;

  localparam int WIDTH_DEF = 16;

  function automatic int levels(input int w);
    int l;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) < w) l = i + 1;
    end
    return l;
  endfunction

  // Stage 1 takes the upper half of the levels so stage 2 never has more.
  function automatic int split(input int l);
    return (l + 1) / 2;
  endfunction

  localparam int LEVELS_DEF = levels(WIDTH_DEF);
  localparam int SPLIT_DEF  = split(LEVELS_DEF);

endpackage

// File: rtl/prefix_cell.sv
// Generate/propagate combine of a higher group with the group just below it.
module prefix_cell #(
  parameter bit HAS_P = 1'b1
) (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  // Groups that reach position 0 have zero propagate, so p is tied off there.
  assign p = HAS_P ? (p_hi & p_lo) : 1'b0;

endmodule

// File: rtl/sklansky_sub_pipe.sv
// Two-stage pipelined A-B-Bin subtractor built on a Sklansky prefix network,
// with valid/ready handshake on both sides.
module sklansky_sub_pipe
  import sklansky_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int L = levels(WIDTH);
  localparam int S = split(L);

  logic             s1_valid, s2_valid, s1_advance, accept;
  logic [WIDTH-1:0] s1_g, s1_p, s1_hs;
  logic             s1_gn, s1_amsb;

  logic [L:0][WIDTH-1:0]   gl;
  logic [L-1:0][WIDTH-1:0] pl;
  logic [L:1][WIDTH-1:0]   gn;
  logic [L-1:1][WIDTH-1:0] pn;
  logic [WIDTH-1:0]        unused_p;

  logic [WIDTH-1:0] d_n;
  logic             cout_n, ovf_n;

  assign s1_advance = ~s2_valid | out_ready;
  assign in_ready   = ~s1_valid | s1_advance;
  assign accept     = in_valid & in_ready;
  assign out_valid  = s2_valid;

  // Position 0 carries the inverted borrow-in; position i+1 holds bit i.
  assign gl[0] = {A[WIDTH-2:0] & ~B[WIDTH-2:0], ~Bin};
  assign pl[0] = {A[WIDTH-2:0] ^ ~B[WIDTH-2:0], 1'b0};

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
      logic p_o;
      if (((i >> (k - 1)) % 2) == 1) begin : g_cell
        localparam int J = ((i >> (k - 1)) << (k - 1)) - 1;
        prefix_cell #(.HAS_P((i >> k) != 0)) u_cell (
          .g_hi(gl[k-1][i]),
          .p_hi(pl[k-1][i]),
          .g_lo(gl[k-1][J]),
          .p_lo(pl[k-1][J]),
          .g   (gn[k][i]),
          .p   (p_o)
        );
      end else begin : g_pass
        assign gn[k][i] = gl[k-1][i];
        assign p_o      = pl[k-1][i];
      end
      if (k < L) begin : g_pmid
        assign pn[k][i] = p_o;
      end else begin : g_plast
        assign unused_p[i] = p_o;
      end
    end
    // Level S feeds the pipeline register; later levels read the registered copy.
    if (k == S) begin : g_cut
      assign gl[k] = s1_g;
      assign pl[k] = s1_p;
    end else if (k < L) begin : g_mid
      assign gl[k] = gn[k];
      assign pl[k] = pn[k];
    end else begin : g_last
      assign gl[k] = gn[k];
    end
  end

  assign d_n    = s1_hs ^ gl[L];
  assign cout_n = s1_gn | (s1_hs[WIDTH-1] & gl[L][WIDTH-1]);
  assign ovf_n  = ~s1_hs[WIDTH-1] & (d_n[WIDTH-1] ^ s1_amsb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
      s1_hs    <= '0;
      s1_gn    <= 1'b0;
      s1_amsb  <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        s1_g    <= gn[S];
        s1_p    <= pn[S];
        s1_hs   <= A ^ ~B;
        s1_gn   <= A[WIDTH-1] & ~B[WIDTH-1];
        s1_amsb <= A[WIDTH-1];
      end
    end
  end

  // Stage 2 holds its result while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      D        <= '0;
      Bout     <= 1'b0;
      Ovf      <= 1'b0;
      Zero     <= 1'b0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        D    <= d_n;
        Bout <= ~cout_n;
        Ovf  <= ovf_n;
        Zero <= (d_n == '0);
      end
    end
  end

endmodule

// File: tb/tb_sklansky_sub_pipe.sv
// Directed and randomized checks of the pipelined Sklansky subtractor at WIDTH=16.
module tb_sklansky_sub_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, bin, bout, ovf, zero;
  logic [W-1:0] a, b, d;
  logic [W+2:0] res;
  logic [W+2:0] q[$];
  logic [W+2:0] e[8];
  int           total = 0;
  int           bad = 0;

  assign res = {d, bout, ovf, zero};

  sklansky_sub_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D        (d),
    .Bout     (bout),
    .Ovf      (ovf),
    .Zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic bi);
    logic [W:0]   diff;
    logic [W-1:0] dd;
    diff = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    dd   = diff[W-1:0];
    return {dd, diff[W], (x[W-1] != y[W-1]) && (dd[W-1] != x[W-1]), dd == '0};
  endfunction

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W+2:0] obs, input logic [W+2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic bi);
    in_valid = v;
    a        = x;
    b        = y;
    bin      = bi;
  endtask

  task automatic oneBeat(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bi, input logic [W+2:0] exp);
    applyStimulus(1'b1, x, y, bi);
    checkBit({tag, "_rdy"}, in_ready, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkBit({tag, "_v1"}, out_valid, 1'b0);
    step();
    checkBit({tag, "_v2"}, out_valid, 1'b1);
    checkOutput({tag, "_res"}, res, exp);
    step();
    checkBit({tag, "_drain"}, out_valid, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    #1;
    checkBit("rst_in_ready", in_ready, 1'b1);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_res", res, '0);
    step();
    step();
    rst_n = 1'b1;
    checkBit("post_rst_in_ready", in_ready, 1'b1);
    checkBit("post_rst_out_valid", out_valid, 1'b0);

    oneBeat("sub_5_3", 16'h0005, 16'h0003, 1'b0, {16'h0002, 1'b0, 1'b0, 1'b0});
    oneBeat("sub_0_1", 16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    oneBeat("sub_zero", 16'h1234, 16'h1233, 1'b1, {16'h0000, 1'b0, 1'b0, 1'b1});
    oneBeat("sub_ovf", 16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});

    // Eight beats back to back, one result per cycle in order.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        applyStimulus(1'b1, W'(c * 256 + 80), W'(c * 3 + 1), c[0]);
        e[c] = model(a, b, bin);
        checkBit("b2b_rdy", in_ready, 1'b1);
      end else begin
        applyStimulus(1'b0, '0, '0, 1'b0);
      end
      step();
      if (c >= 1 && c <= 8) begin
        checkBit("b2b_valid", out_valid, 1'b1);
        checkOutput("b2b_res", res, e[c-1]);
      end else begin
        checkBit("b2b_idle", out_valid, 1'b0);
      end
    end

    // Downstream stall: two beats fill the pipe, third is held off.
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0300, 16'h0100, 1'b0);
    checkBit("stall_rdy0", in_ready, 1'b1);
    step();
    applyStimulus(1'b1, 16'h0040, 16'h0041, 1'b0);
    checkBit("stall_rdy1", in_ready, 1'b1);
    step();
    applyStimulus(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkBit("stall_blocked", in_ready, 1'b0);
      checkBit("stall_valid", out_valid, 1'b1);
      checkOutput("stall_hold", res, {16'h0200, 1'b0, 1'b0, 1'b0});
      step();
    end
    out_ready = 1'b1;
    #1;
    checkBit("stall_release_rdy", in_ready, 1'b1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkBit("stall_b_valid", out_valid, 1'b1);
    checkOutput("stall_b_res", res, {16'hFFFF, 1'b1, 1'b0, 1'b0});
    step();
    checkBit("stall_c_valid", out_valid, 1'b1);
    checkOutput("stall_c_res", res, {16'h8000, 1'b1, 1'b1, 1'b0});
    step();
    checkBit("stall_empty", out_valid, 1'b0);

    // Reset with two beats in flight.
    applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0);
    step();
    applyStimulus(1'b1, 16'h0003, 16'h0004, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0);
    checkBit("midrst_pre_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    checkBit("midrst_valid", out_valid, 1'b0);
    checkBit("midrst_rdy", in_ready, 1'b1);
    checkOutput("midrst_res", res, '0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkBit("midrst_no_stale", out_valid, 1'b0);
      step();
    end
    oneBeat("midrst_new", 16'h0010, 16'h0008, 1'b0, {16'h0008, 1'b0, 1'b0, 1'b0});

    // Random beats and stalls against the arithmetic model.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
                    1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        checkBit("rnd_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) checkOutput("rnd_res", res, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(a, b, bin));
      step();
    end
    applyStimulus(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        checkBit("drain_expected", q.size() > 0, 1'b1);
        if (q.size() > 0) checkOutput("drain_res", res, q.pop_front());
      end
      step();
    end
    checkBit("rnd_all_returned", q.size() == 0, 1'b1);
    checkBit("rnd_idle", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
